// File: rtl/decimator_pkg.sv
// Shared definitions for the decimating FIFO stage.
// Holds the level-width helper, the rescale (round + limit) function and
// the default output range constants.
package decimator_pkg;

    localparam int DEFAULT_DATA_WIDTH = 9;
    localparam int DEFAULT_OUT_WIDTH  = 8;

    // Rescale arithmetic is carried out on a fixed wide signed word so the
    // function can serve any DATA_WIDTH/OUT_WIDTH pair up to 30 bits.
    localparam int CALC_WIDTH = 32;

    localparam int OUT_MAX = (2 ** (DEFAULT_OUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (DEFAULT_OUT_WIDTH - 1));

    typedef logic signed [CALC_WIDTH-1:0] calc_t;

    typedef struct packed {
        calc_t value;
        logic  clamped;
    } rescale_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Round half up, arithmetic shift, then clamp or wrap to out_width bits.
    // x is the sign-extended (DATA_WIDTH+1)-bit sample widened to calc_t.
    function automatic rescale_t rescale(input calc_t x,
                                         input int    shift,
                                         input int    out_width,
                                         input logic  sat_en);
        calc_t    rounded;
        calc_t    shifted;
        calc_t    hi;
        calc_t    lo;
        rescale_t r;

        if (shift > 0) begin
            rounded = x + (calc_t'(32'sd1) <<< (shift - 1));
        end else begin
            rounded = x;
        end
        shifted   = rounded >>> shift;
        hi        = (calc_t'(32'sd1) <<< (out_width - 1)) - calc_t'(32'sd1);
        lo        = -(calc_t'(32'sd1) <<< (out_width - 1));
        r.clamped = 1'b0;
        r.value   = shifted;
        if (sat_en) begin
            if (shifted > hi) begin
                r.value   = hi;
                r.clamped = 1'b1;
            end else if (shifted < lo) begin
                r.value   = lo;
                r.clamped = 1'b1;
            end else begin
                r.value   = shifted;
            end
        end else begin
            // Two's-complement wrap: keep only the low out_width bits.
            r.value = (shifted <<< (CALC_WIDTH - out_width)) >>> (CALC_WIDTH - out_width);
        end
        return r;
    endfunction

endpackage

// File: rtl/decimator_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head word is kept in its own register so o_rdata is a flop output.
// Storage array is not reset; only pointers, level and head are.
module sync_fifo
    import decimator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_valid,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_next_s;
    logic [LVL_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = !valid_q;
    assign o_valid = valid_q;
    assign o_level = level_q;
    assign o_rdata = head_q;

    // Accept decisions: a push into a full FIFO only succeeds alongside a pop.
    always_comb begin
        pop_ok_s  = i_pop && (level_q != {LVL_W{1'b0}});
        push_ok_s = i_push && (!o_full || pop_ok_s);
        rd_next_s = rd_ptr_q + PTR_W'(1);
    end

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_next_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        valid_d = (level_d != {LVL_W{1'b0}});
    end

    // Head word next-state: next stored entry, or the incoming word when it
    // becomes the only entry; otherwise hold (also holds while empty).
    always_comb begin
        head_d = head_q;
        if (pop_ok_s) begin
            if (level_q > LVL_W'(1)) begin
                head_d = mem_q[rd_next_s];
            end else if (push_ok_s) begin
                head_d = i_wdata;
            end else begin
                head_d = head_q;
            end
        end else if ((level_q == {LVL_W{1'b0}}) && push_ok_s) begin
            head_d = i_wdata;
        end else begin
            head_d = head_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            valid_q  <= 1'b0;
            head_q   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule

// File: rtl/decimator_fifo.sv
// Decimating FIFO stage: keeps one of every DECIM_FACTOR strobed samples,
// rounds/shifts/limits it, and buffers it behind a valid/ready interface.
// Optional feature macro: DECIMATOR_FIFO_SAT_EN selects clamping with a
// sticky o_overflow; when undefined results wrap and o_overflow stays 0.
module decimator_fifo
    import decimator_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int OUT_WIDTH    = DEFAULT_OUT_WIDTH,
    parameter int SHIFT        = 1,
    parameter int DECIM_FACTOR = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_ce,
    input  logic signed [DATA_WIDTH-1:0]       i_data,
    output logic signed [OUT_WIDTH-1:0]        o_data,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [level_width(FIFO_DEPTH)-1:0] o_level,
    output logic                               o_drop,
    output logic                               o_overflow
);

    localparam int PH_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;

`ifdef DECIMATOR_FIFO_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [PH_W-1:0]             phase_q, phase_d;
    logic                        keep_s;
    logic signed [DATA_WIDTH:0]  x_ext_s;
    rescale_t                    res_s;
    logic                        s1_valid_q, s1_valid_d;
    logic [OUT_WIDTH-1:0]        s1_data_q, s1_data_d;
    logic                        drop_q, drop_d;
    logic                        overflow_q, overflow_d;
    logic                        pop_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [OUT_WIDTH-1:0]        fifo_rdata_s;
    logic                        unused_s;

    // Phase counter: only strobes advance it; phase 0 marks a kept sample.
    always_comb begin
        keep_s = i_ce && (phase_q == {PH_W{1'b0}});
        if (i_ce) begin
            if (phase_q == PH_W'(DECIM_FACTOR - 1)) begin
                phase_d = {PH_W{1'b0}};
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Rescale of the incoming sample (only consumed when it is kept).
    always_comb begin
        x_ext_s = {i_data[DATA_WIDTH-1], i_data};
        res_s   = rescale(calc_t'(x_ext_s), SHIFT, OUT_WIDTH, SAT_EN);
    end

    // Stage-1 register next-state: capture the rescaled value of kept samples.
    always_comb begin
        s1_valid_d = keep_s;
        if (keep_s) begin
            s1_data_d = res_s.value[OUT_WIDTH-1:0];
        end else begin
            s1_data_d = s1_data_q;
        end
    end

    // Sticky flags: drop on push into a full FIFO with no pop, overflow on clamp.
    always_comb begin
        pop_s = o_valid && i_ready;
        if (s1_valid_q && fifo_full_s && !pop_s) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
        if (keep_s && res_s.clamped) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pipeline and flag registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q    <= {PH_W{1'b0}};
            s1_valid_q <= 1'b0;
            s1_data_q  <= {OUT_WIDTH{1'b0}};
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (s1_valid_q),
        .i_wdata (s1_data_q),
        .i_pop   (pop_s),
        .o_rdata (fifo_rdata_s),
        .o_valid (o_valid),
        .o_empty (fifo_empty_s),
        .o_full  (fifo_full_s),
        .o_level (o_level)
    );

    assign o_data     = fifo_rdata_s;
    assign o_drop     = drop_q;
    assign o_overflow = overflow_q;

    // Upper bits of the wide rescale word and the empty flag are not needed.
    assign unused_s = ^{res_s.value[CALC_WIDTH-1:OUT_WIDTH], fifo_empty_s};

endmodule

// File: tb/tb_decimator_fifo.sv
// Bench for decimator_fifo: two instances (A: DECIM 4 / SHIFT 0,
// B: DECIM 1 / SHIFT 1), a queue-level reference model checked every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
module tb_decimator_fifo;

    localparam int NI    = 2;
    localparam int DEPTH = 8;

`ifdef DECIMATOR_FIFO_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              ce   [NI];
    logic signed [8:0] din  [NI];
    logic              rdy  [NI];
    logic signed [7:0] dout [NI];
    logic              vld  [NI];
    logic [3:0]        lvl  [NI];
    logic              drp  [NI];
    logic              ovf  [NI];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_cnt [NI];
    bit m_s1v [NI];
    int m_s1d [NI];
    int m_mem [NI][DEPTH];
    int m_hd  [NI];
    int m_sz  [NI];
    bit m_drop[NI];
    bit m_ovf [NI];

    // values popped during directed phases
    int cap  [NI][32];
    int ncap [NI];

    decimator_fifo #(.DATA_WIDTH(9), .OUT_WIDTH(8), .SHIFT(0), .DECIM_FACTOR(4), .FIFO_DEPTH(8)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_ce(ce[0]), .i_data(din[0]), .o_data(dout[0]),
        .o_valid(vld[0]), .i_ready(rdy[0]), .o_level(lvl[0]), .o_drop(drp[0]), .o_overflow(ovf[0]));

    decimator_fifo #(.DATA_WIDTH(9), .OUT_WIDTH(8), .SHIFT(1), .DECIM_FACTOR(1), .FIFO_DEPTH(8)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_ce(ce[1]), .i_data(din[1]), .o_data(dout[1]),
        .o_valid(vld[1]), .i_ready(rdy[1]), .o_level(lvl[1]), .o_drop(drp[1]), .o_overflow(ovf[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int df(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int sh(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // Plain-arithmetic rescale: floor((x + half) / 2^sh), then clamp or wrap to 8 bits.
    function automatic int ref_scale(int x, int s, output bit clamp);
        int num, den, q;
        num = x + ((s > 0) ? (1 << (s - 1)) : 0);
        den = 1 << s;
        if (num >= 0) q = num / den;
        else          q = -((-num + den - 1) / den);
        clamp = 1'b0;
        if (SAT) begin
            if (q > 127) begin q = 127; clamp = 1'b1; end
            else if (q < -128) begin q = -128; clamp = 1'b1; end
        end else begin
            q = ((q % 256) + 256) % 256;
            if (q > 127) q = q - 256;
        end
        return q;
    endfunction

    task automatic model_clear(int i);
        m_cnt[i] = 0; m_s1v[i] = 1'b0; m_s1d[i] = 0;
        m_hd[i] = 0; m_sz[i] = 0; m_drop[i] = 1'b0; m_ovf[i] = 1'b0;
    endtask

    task automatic model_step(int i, bit c, int d, bit r);
        bit pop, acc, keep, cl;
        int v;
        pop = (m_sz[i] > 0) && r;
        acc = 1'b0;
        if (m_s1v[i]) begin
            if (m_sz[i] < DEPTH || pop) acc = 1'b1;
            else                        m_drop[i] = 1'b1;
        end
        if (pop) begin
            m_hd[i] = (m_hd[i] + 1) % DEPTH;
            m_sz[i] = m_sz[i] - 1;
        end
        if (acc) begin
            m_mem[i][(m_hd[i] + m_sz[i]) % DEPTH] = m_s1d[i];
            m_sz[i] = m_sz[i] + 1;
        end
        keep = c && (m_cnt[i] == 0);
        if (c) m_cnt[i] = (m_cnt[i] + 1) % df(i);
        m_s1v[i] = keep;
        if (keep) begin
            v = ref_scale(d, sh(i), cl);
            m_s1d[i] = v;
            if (cl) m_ovf[i] = 1'b1;
        end
    endtask

    task automatic check(string name, int inst, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    endtask

    // Model advances on every rising edge using the inputs the DUT samples.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) model_clear(i);
                else     model_step(i, ce[i], int'(din[i]), rdy[i]);
            end
        end
    end

    // Compare outputs against the model on every falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check("valid", i, int'(vld[i]), (m_sz[i] > 0) ? 1 : 0);
                check("level", i, int'(lvl[i]), m_sz[i]);
                check("drop", i, int'(drp[i]), int'(m_drop[i]));
                check("overflow", i, int'(ovf[i]), int'(m_ovf[i]));
                if (m_sz[i] > 0) check("data", i, int'(dout[i]), m_mem[i][m_hd[i]]);
            end
        end
    end

    // Drive one instance for one cycle (other instance idles); log the word popped at the next edge.
    task automatic drive(int i, bit c, int d, bit r);
        logic [31:0] dv;
        dv = d;
        ce[i] = c; din[i] = dv[8:0]; rdy[i] = r;
        ce[1 - i] = 1'b0;
        if (vld[i] && r && ncap[i] < 32) begin
            cap[i][ncap[i]] = int'(dout[i]);
            ncap[i]++;
        end
        @(negedge clk);
    endtask

    task automatic idle(int i, bit r, int n);
        for (int k = 0; k < n; k++) drive(i, 1'b0, 0, r);
    endtask

    task automatic pulse_reset();
        ce[0] = 1'b0; ce[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        int exp_round [4];
        int exp_bp [8];
        int blk, pce, prdy;
        logic [31:0] rv;
        exp_round = '{2, -1, 3, 0};
        exp_bp    = '{5, 6, 6, 7, 7, 8, 8, 9};
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            ce[i] = 1'b0; din[i] = 9'sd0; rdy[i] = 1'b1; ncap[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_valid", i, int'(vld[i]), 0);
            check("rst_level", i, int'(lvl[i]), 0);
            check("rst_drop", i, int'(drp[i]), 0);
            check("rst_overflow", i, int'(ovf[i]), 0);
            check("rst_data", i, int'(dout[i]), 0);
        end
        rst = 1'b0;

        // decimation on A: keep 0,4,8; first valid two cycles after first strobe
        ncap[0] = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) check("lat_n1_valid", 0, int'(vld[0]), 0);
            if (k == 2) check("lat_n2_valid", 0, int'(vld[0]), 1);
            drive(0, 1'b1, k, 1'b1);
        end
        idle(0, 1'b1, 4);
        check("decim_count", 0, ncap[0], 3);
        check("decim_0", 0, cap[0][0], 0);
        check("decim_1", 0, cap[0][1], 4);
        check("decim_2", 0, cap[0][2], 8);

        // limiting on A (phase is 0 again after 12 strobes)
        ncap[0] = 0;
        drive(0, 1'b1, 200, 1'b1);
        drive(0, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 0, 1'b1);
        drive(0, 1'b1, 0, 1'b1);
        drive(0, 1'b1, -200, 1'b1);
        idle(0, 1'b1, 4);
        check("lim_count", 0, ncap[0], 2);
        check("lim_pos", 0, cap[0][0], SAT ? 127 : -56);
        check("lim_neg", 0, cap[0][1], SAT ? -128 : 56);
        check("lim_overflow", 0, int'(ovf[0]), SAT ? 1 : 0);

        // rounding on B
        ncap[1] = 0;
        drive(1, 1'b1, 3, 1'b1);
        drive(1, 1'b1, -3, 1'b1);
        drive(1, 1'b1, 5, 1'b1);
        drive(1, 1'b1, -1, 1'b1);
        idle(1, 1'b1, 4);
        check("round_count", 1, ncap[1], 4);
        for (int k = 0; k < 4; k++) check("round_val", 1, cap[1][k], exp_round[k]);

        // back-pressure on B: 10 strobes into depth 8
        for (int v = 10; v < 20; v++) drive(1, 1'b1, v, 1'b0);
        idle(1, 1'b0, 2);
        check("bp_level", 1, int'(lvl[1]), 8);
        check("bp_drop", 1, int'(drp[1]), 1);
        ncap[1] = 0;
        idle(1, 1'b1, 10);
        check("bp_count", 1, ncap[1], 8);
        for (int k = 0; k < 8; k++) check("bp_order", 1, cap[1][k], exp_bp[k]);

        // full FIFO with push and pop on the same edge
        pulse_reset();
        for (int v = 20; v < 28; v++) drive(1, 1'b1, v, 1'b0);
        idle(1, 1'b0, 2);
        check("full_level", 1, int'(lvl[1]), 8);
        drive(1, 1'b1, 30, 1'b0);
        drive(1, 1'b0, 0, 1'b1);
        check("pushpop_level", 1, int'(lvl[1]), 8);
        check("pushpop_drop", 1, int'(drp[1]), 0);
        check("pushpop_head", 1, int'(dout[1]), 11);
        idle(1, 1'b1, 12);

        // mid-stream reset on A with 5 entries and phase 2
        pulse_reset();
        for (int k = 0; k < 18; k++) drive(0, 1'b1, k, 1'b0);
        idle(0, 1'b0, 2);
        check("pre_rst_level", 0, int'(lvl[0]), 5);
        pulse_reset();
        check("mid_rst_valid", 0, int'(vld[0]), 0);
        check("mid_rst_level", 0, int'(lvl[0]), 0);
        check("mid_rst_drop", 0, int'(drp[0]), 0);
        drive(0, 1'b1, 7, 1'b0);
        idle(0, 1'b0, 1);
        check("post_rst_valid", 0, int'(vld[0]), 1);
        check("post_rst_data", 0, int'(dout[0]), 7);

        // randomized traffic on both instances
        pulse_reset();
        for (int n = 0; n < 4000; n++) begin
            blk  = n / 1000;
            pce  = (blk == 0) ? 90 : (blk == 1) ? 50 : (blk == 2) ? 100 : 30;
            prdy = (blk == 0) ? 50 : (blk == 1) ? 90 : (blk == 2) ? 20 : 100;
            for (int i = 0; i < NI; i++) begin
                rv = $urandom_range(0, 511);
                ce[i]  = ($urandom_range(0, 99) < pce);
                din[i] = rv[8:0];
                rdy[i] = ($urandom_range(0, 99) < prdy);
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        ce[0] = 1'b0; ce[1] = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
